cnn_layer_accel_quad_job_ctrl: RTL and testbench

Quad-side responder for the job handshake that the host or testbench initiates on clk_if. It accepts job_start/job_parameters and decodes the parameters into registered cfg fields. It then issues one fetch request per kernel group and counts result beats until the job's output volume is consumed. Finally it raises job_complete and holds it until acknowledged. It sits between the host job interface and the quad datapath, and is the counterpart of the host-side job driver.

---
 rtl/cnn_layer_accel_quad_job_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cnn_layer_accel_quad_job_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_quad_job_ctrl.sv
// Quad-side job controller: accepts a job descriptor, runs one fetch per kernel group,
// counts result beats to the job's output volume, then holds job_complete until acked.
// Optional watchdog is compiled in with CNN_JOB_TIMEOUT_EN.
module cnn_layer_accel_quad_job_ctrl #(
  parameter int C_KERNELS_PER_FETCH = 8,
  parameter int C_TIMEOUT_CYCLES    = 65535
) (
  input  logic         clk_if,
  input  logic         rst,
  input  logic         job_start,
  output logic         job_accept,
  input  logic [127:0] job_parameters,
  output logic         job_fetch_request,
  input  logic         job_fetch_ack,
  input  logic         job_fetch_complete,
  output logic         job_complete,
  input  logic         job_complete_ack,
  input  logic         result_valid,
  input  logic         result_accept,
  output logic [6:0]   num_kernels_cfg,
  output logic [9:0]   num_output_rows_cfg,
  output logic [9:0]   num_output_cols_cfg,
  output logic [6:0]   stride_cfg,
  output logic [4:0]   padding_cfg,
  output logic         upsample_cfg,
  output logic         master_quad_cfg,
  output logic         job_busy,
  output logic         job_err,
  output logic [26:0]  result_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_RUN,
    S_COMPLETE
  } state_t;

  localparam int LOG2K = $clog2(C_KERNELS_PER_FETCH);

  state_t      state, state_next;
  logic        ready_q;
  logic        fetch_req_q;
  logic [26:0] total_q;
  logic [26:0] total_in;
  logic [26:0] count_inc;
  logic [6:0]  group_cnt;
  logic [6:0]  num_groups;
  logic [7:0]  kernels_round;
  logic        beat;
  logic        count_beat;
  logic        accept_fire;
  logic        group_done;
  logic        last_group;
  logic        timeout_hit;
  logic        params_unused;

  assign params_unused = ^job_parameters[127:41];

  // ready_q keeps job_accept low until the first edge after reset release.
  assign job_accept        = ready_q && (state == S_IDLE);
  assign job_busy          = (state != S_IDLE);
  assign job_complete      = (state == S_COMPLETE);
  assign job_fetch_request = fetch_req_q;

  assign beat        = result_valid && result_accept;
  assign count_beat  = beat && (state inside {S_FETCH_REQ, S_FETCH_WAIT, S_RUN});
  assign accept_fire = job_start && job_accept;
  assign total_in    = 27'(job_parameters[6:0]) * 27'(job_parameters[16:7])
                     * 27'(job_parameters[26:17]);
  assign count_inc   = result_count + {26'd0, count_beat};

  // Group count is ceil(kernels / C_KERNELS_PER_FETCH) via round-up and shift.
  assign kernels_round = {1'b0, num_kernels_cfg} + 8'(C_KERNELS_PER_FETCH - 1);
  assign num_groups    = 7'(kernels_round >> LOG2K);
  assign last_group    = ({1'b0, group_cnt} + 8'd1) >= {1'b0, num_groups};
  assign group_done    = job_fetch_complete &&
                         ((state == S_FETCH_WAIT) || (state == S_FETCH_REQ && job_fetch_ack));

`ifdef CNN_JOB_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_active;

  // Watchdog runs only while waiting and restarts on any fetch completion or counted beat.
  assign wd_active   = (state == S_FETCH_WAIT || state == S_RUN) && !(group_done || count_beat);
  assign timeout_hit = wd_active && (wd_cnt == 32'(C_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_active ? wd_cnt + 32'd1 : '0;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (C_TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    // NOTE: default assigned first so no branch leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:
        if (accept_fire) state_next = (total_in == '0) ? S_COMPLETE : S_FETCH_REQ;
      S_FETCH_REQ:
        if (job_fetch_ack) begin
          if (group_done) state_next = last_group ? S_RUN : S_FETCH_REQ;
          else            state_next = S_FETCH_WAIT;
        end
      S_FETCH_WAIT:
        if (group_done) state_next = last_group ? S_RUN : S_FETCH_REQ;
      S_RUN:
        if (count_inc >= total_q) state_next = S_COMPLETE;
      S_COMPLETE:
        if (job_complete_ack) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_COMPLETE;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      ready_q             <= 1'b0;
      fetch_req_q         <= 1'b0;
      total_q             <= '0;
      group_cnt           <= '0;
      result_count        <= '0;
      job_err             <= 1'b0;
      num_kernels_cfg     <= '0;
      num_output_rows_cfg <= '0;
      num_output_cols_cfg <= '0;
      stride_cfg          <= '0;
      padding_cfg         <= '0;
      upsample_cfg        <= 1'b0;
      master_quad_cfg     <= 1'b0;
    end else begin
      state       <= state_next;
      ready_q     <= 1'b1;
      fetch_req_q <= (state_next == S_FETCH_REQ);
      if (accept_fire) begin
        num_kernels_cfg     <= job_parameters[6:0];
        num_output_rows_cfg <= job_parameters[16:7];
        num_output_cols_cfg <= job_parameters[26:17];
        stride_cfg          <= job_parameters[33:27];
        padding_cfg         <= job_parameters[38:34];
        upsample_cfg        <= job_parameters[39];
        master_quad_cfg     <= job_parameters[40];
        total_q             <= total_in;
        group_cnt           <= '0;
        result_count        <= '0;
        job_err             <= (total_in == '0);
      end else begin
        if (count_beat) result_count <= count_inc;
        if (group_done) group_cnt <= group_cnt + 7'd1;
        if ((state == S_COMPLETE && beat) || timeout_hit) job_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_quad_job_ctrl.sv
// Randomized self-checking bench for cnn_layer_accel_quad_job_ctrl; expectations come from
// job arithmetic (volume, group count, latencies). Timeout scenario follows CNN_JOB_TIMEOUT_EN.
module tb_cnn_layer_accel_quad_job_ctrl;

  localparam int KPF = 8;
  localparam int TIMEOUT = 100;

  logic         clk_if = 1'b0;
  logic         rst = 1'b0;
  logic         job_start = 1'b0;
  logic         job_accept;
  logic [127:0] job_parameters = '0;
  logic         job_fetch_request;
  logic         job_fetch_ack = 1'b0;
  logic         job_fetch_complete = 1'b0;
  logic         job_complete;
  logic         job_complete_ack = 1'b0;
  logic         result_valid = 1'b0;
  logic         result_accept = 1'b0;
  logic [6:0]   num_kernels_cfg;
  logic [9:0]   num_output_rows_cfg;
  logic [9:0]   num_output_cols_cfg;
  logic [6:0]   stride_cfg;
  logic [4:0]   padding_cfg;
  logic         upsample_cfg;
  logic         master_quad_cfg;
  logic         job_busy;
  logic         job_err;
  logic [26:0]  result_count;

  int n_cmp = 0;
  int n_bad = 0;

  cnn_layer_accel_quad_job_ctrl #(
    .C_KERNELS_PER_FETCH(KPF),
    .C_TIMEOUT_CYCLES   (TIMEOUT)
  ) dut (
    .clk_if             (clk_if),
    .rst                (rst),
    .job_start          (job_start),
    .job_accept         (job_accept),
    .job_parameters     (job_parameters),
    .job_fetch_request  (job_fetch_request),
    .job_fetch_ack      (job_fetch_ack),
    .job_fetch_complete (job_fetch_complete),
    .job_complete       (job_complete),
    .job_complete_ack   (job_complete_ack),
    .result_valid       (result_valid),
    .result_accept      (result_accept),
    .num_kernels_cfg    (num_kernels_cfg),
    .num_output_rows_cfg(num_output_rows_cfg),
    .num_output_cols_cfg(num_output_cols_cfg),
    .stride_cfg         (stride_cfg),
    .padding_cfg        (padding_cfg),
    .upsample_cfg       (upsample_cfg),
    .master_quad_cfg    (master_quad_cfg),
    .job_busy           (job_busy),
    .job_err            (job_err),
    .result_count       (result_count)
  );

  always #5 clk_if = ~clk_if;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [40:0] cfg_now();
    return {master_quad_cfg, upsample_cfg, padding_cfg, stride_cfg,
            num_output_cols_cfg, num_output_rows_cfg, num_kernels_cfg};
  endfunction

  function automatic logic [40:0] cfg_exp(int k, int r, int c, int s, int p, bit up, bit mq);
    return {mq, up, 5'(p), 7'(s), 10'(c), 10'(r), 7'(k)};
  endfunction

  function automatic logic [127:0] mk_params(int k, int r, int c, int s, int p, bit up, bit mq);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[6:0]   = 7'(k);
    v[16:7]  = 10'(r);
    v[26:17] = 10'(c);
    v[33:27] = 7'(s);
    v[38:34] = 5'(p);
    v[39]    = up;
    v[40]    = mq;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_if);
    #1;
  endtask

  task automatic start_job(input logic [127:0] p, output bit ok);
    job_parameters = p;
    job_start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (job_accept) ok = 1'b1;
      step();
    end
    job_start = 1'b0;
  endtask

  // Host side of the fetch handshake; stops once no request appears for 20 cycles.
  task automatic serve_fetches(input int same_round, output int rounds);
    int idle = 0;
    rounds = 0;
    while (idle < 20) begin
      if (job_fetch_request) begin
        rounds++;
        job_fetch_ack = 1'b1;
        job_fetch_complete = (rounds == same_round);
        step();
        job_fetch_ack = 1'b0;
        if (!job_fetch_complete) begin
          repeat ($urandom_range(0, 3)) step();
          job_fetch_complete = 1'b1;
          step();
        end
        job_fetch_complete = 1'b0;
        idle = 0;
      end else begin
        step();
        idle++;
      end
    end
  endtask

  task automatic send_beats(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 5000) begin
      result_valid  = ($urandom_range(0, 3) != 0);
      result_accept = ($urandom_range(0, 3) != 0);
      if (result_valid && result_accept) got++;
      step();
      guard++;
    end
    result_valid  = 1'b0;
    result_accept = 1'b0;
  endtask

  task automatic finish_job(input string name);
    job_complete_ack = 1'b1;
    step();
    job_complete_ack = 1'b0;
    n_cmp++;
    if (job_accept !== 1'b1 || job_complete !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ack: accept=%b complete=%b, required accept=1 complete=0",
               name, job_accept, job_complete);
    end
  endtask

  // Full nonzero job up to job_complete; leaves the block in COMPLETE.
  task automatic do_job(input string name, input int k, input int r, input int c,
                        input int s, input int p, input bit up, input bit mq,
                        input int same_round);
    bit ok;
    int rounds;
    int total = k * r * c;
    int groups = (k + KPF - 1) / KPF;
    start_job(mk_params(k, r, c, s, p, up, mq), ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_accept: job not accepted within 50 cycles", name);
    end
    n_cmp++;
    if (job_fetch_request !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_fetch_latency: fetch_request=%b, required 1", name, job_fetch_request);
    end
    serve_fetches(same_round, rounds);
    n_cmp++;
    if (rounds != groups) begin
      n_bad++;
      $display("FAIL %s_rounds: got %0d fetch rounds, required %0d", name, rounds, groups);
    end
    send_beats(total - 1);
    n_cmp++;
    if (result_count !== 27'(total - 1) || job_complete !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_pre_last: count=%0d complete=%b, required count=%0d complete=0",
               name, result_count, job_complete, total - 1);
    end
    send_beats(1);
    n_cmp++;
    if (job_complete !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_complete_latency: complete=%b, required 1", name, job_complete);
    end
    n_cmp++;
    if (result_count !== 27'(total)) begin
      n_bad++;
      $display("FAIL %s_count: got %0d, required %0d", name, result_count, total);
    end
    n_cmp++;
    if (job_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_err: got %b, required 0", name, job_err);
    end
    n_cmp++;
    if (cfg_now() !== cfg_exp(k, r, c, s, p, up, mq)) begin
      n_bad++;
      $display("FAIL %s_cfg: got %h, required %h", name, cfg_now(), cfg_exp(k, r, c, s, p, up, mq));
    end
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if ({job_accept, job_busy, job_complete, job_fetch_request, job_err} !== 5'b0 ||
        result_count !== '0 || cfg_now() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: flags=%b count=%0d cfg=%h, required all 0",
               {job_accept, job_busy, job_complete, job_fetch_request, job_err},
               result_count, cfg_now());
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (job_accept !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_accept_early: got %b, required 0", job_accept);
    end
    step();
    n_cmp++;
    if (job_accept !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_accept: got %b, required 1", job_accept);
    end
  endtask

  task automatic test_basic();
    do_job("basic", 8, 2, 3, 1, 0, 1'b0, 1'b1, 0);
    result_valid = 1'b1;
    result_accept = 1'b1;
    step();
    result_valid = 1'b0;
    result_accept = 1'b0;
    n_cmp++;
    if (job_err !== 1'b1 || result_count !== 27'd48) begin
      n_bad++;
      $display("FAIL basic_beat_in_complete: err=%b count=%0d, required err=1 count=48",
               job_err, result_count);
    end
    finish_job("basic");
  endtask

  task automatic test_multi_group();
    do_job("multi", 20, 1, 1, 2, 1, 1'b1, 1'b0, 0);
    finish_job("multi");
    do_job("multi_same", 20, 1, 1, 4, 3, 1'b0, 1'b0, 2);
    finish_job("multi_same");
  endtask

  task automatic test_zero_job();
    bit ok;
    start_job(mk_params(5, 0, 3, 1, 1, 1'b0, 1'b0), ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL zero_accept: job not accepted within 50 cycles");
    end
    n_cmp++;
    if (job_complete !== 1'b1 || job_err !== 1'b1 || result_count !== '0 ||
        job_fetch_request !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_job: complete=%b err=%b count=%0d fetch=%b, required 1 1 0 0",
               job_complete, job_err, result_count, job_fetch_request);
    end
    finish_job("zero");
  endtask

  task automatic test_busy_reject();
    bit ok;
    bit seen_accept = 1'b0;
    int rounds;
    start_job(mk_params(8, 1, 2, 3, 2, 1'b1, 1'b1), ok);
    serve_fetches(0, rounds);
    send_beats(5);
    job_parameters = mk_params(50, 9, 9, 7, 7, 1'b0, 1'b0);
    job_start = 1'b1;
    repeat (3) begin
      seen_accept |= job_accept;
      step();
    end
    job_start = 1'b0;
    n_cmp++;
    if (seen_accept !== 1'b0 || !ok) begin
      n_bad++;
      $display("FAIL busy_accept: accept seen=%b first_ok=%b, required 0 and 1", seen_accept, ok);
    end
    n_cmp++;
    if (cfg_now() !== cfg_exp(8, 1, 2, 3, 2, 1'b1, 1'b1)) begin
      n_bad++;
      $display("FAIL busy_cfg: got %h, required %h", cfg_now(), cfg_exp(8, 1, 2, 3, 2, 1'b1, 1'b1));
    end
    send_beats(11);
    n_cmp++;
    if (job_complete !== 1'b1 || result_count !== 27'd16) begin
      n_bad++;
      $display("FAIL busy_complete: complete=%b count=%0d, required 1 and 16",
               job_complete, result_count);
    end
    finish_job("busy");
    repeat (3) step();
    n_cmp++;
    if (job_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_not_queued: busy=%b, required 0", job_busy);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      int k = $urandom_range(1, 40);
      int g = (k + KPF - 1) / KPF;
      do_job($sformatf("rand%0d", j), k, $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(0, 127), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, g));
      finish_job($sformatf("rand%0d", j));
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int rounds;
    start_job(mk_params(8, 4, 1, 1, 0, 1'b0, 1'b1), ok);
    serve_fetches(0, rounds);
    send_beats(17);
    n_cmp++;
    if (result_count !== 27'd17 || !ok) begin
      n_bad++;
      $display("FAIL areset_pre_count: got %0d, required 17", result_count);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({job_accept, job_busy, job_complete, job_fetch_request, job_err} !== 5'b0 ||
        result_count !== '0 || cfg_now() !== '0) begin
      n_bad++;
      $display("FAIL areset_outputs: flags=%b count=%0d cfg=%h, required all 0",
               {job_accept, job_busy, job_complete, job_fetch_request, job_err},
               result_count, cfg_now());
    end
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (job_accept !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_accept_early: got %b, required 0", job_accept);
    end
    step();
    n_cmp++;
    if (job_accept !== 1'b1 || job_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_accept: accept=%b busy=%b, required 1 and 0", job_accept, job_busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cycles = 0;
    start_job(mk_params(8, 1, 1, 1, 0, 1'b0, 1'b0), ok);
    n_cmp++;
    if (!ok || job_fetch_request !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_setup: accepted=%b fetch=%b, required 1 and 1", ok, job_fetch_request);
    end
    job_fetch_ack = 1'b1;
    step();
    job_fetch_ack = 1'b0;
    while (!job_complete && cycles < 1000) begin
      step();
      cycles++;
    end
`ifdef CNN_JOB_TIMEOUT_EN
    n_cmp++;
    if (cycles != TIMEOUT || job_err !== 1'b1 || job_fetch_request !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_fire: after %0d cycles complete=%b err=%b, required %0d cycles err=1",
               cycles, job_complete, job_err, TIMEOUT);
    end
    finish_job("timeout");
`else
    n_cmp++;
    if (job_complete !== 1'b0 || job_busy !== 1'b1 || cycles != 1000) begin
      n_bad++;
      $display("FAIL timeout_absent: complete=%b busy=%b after %0d cycles, required 0 1 1000",
               job_complete, job_busy, cycles);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_group();
    test_zero_job();
    test_busy_reject();
    test_random();
    test_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
